// File: rtl/dma_read_scheduler_if.sv
// Bundle of the command, memory-request, memory-response and FIFO signals
// around dma_read_scheduler.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid && ready are both high. Once valid is raised, the
// payload (addr/len) stays stable until that edge. ready may depend on
// valid; valid never depends on ready. rsp_valid and fifo_pop are single-
// cycle strobes with no back-pressure.
//
// Modports:
//   master - the scheduler: consumes commands, issues bursts, pushes FIFO
//   slave  - the environment: command source, memory port and FIFO consumer
interface dma_read_scheduler_if #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int BITS_DEPTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [LEN_W-1:0]      cmd_len;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic [BITS_DEPTH:0]   req_len;
    logic                  rsp_valid;
    logic                  fifo_wr_en;
    logic                  fifo_pop;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, req_ready, rsp_valid, fifo_pop,
        output cmd_ready, req_valid, req_addr, req_len, fifo_wr_en
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, req_ready, rsp_valid, fifo_pop,
        input  cmd_ready, req_valid, req_addr, req_len, fifo_wr_en
    );
endinterface

// File: rtl/dma_read_scheduler.sv
// dma_read_scheduler
// Splits one read command (byte address, length in 32-bit words) into
// memory bursts of at most MAX_BURST words that never cross a
// 2**BOUNDARY_BITS byte boundary. A burst is only issued once the credit
// counter (free FIFO slots not yet promised to in-flight data) covers it.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   bus              command / request / response / FIFO signals (master)
//   busy             FSM is not idle
//   done             one-cycle pulse when a command completes
//   error            sticky: beat with nothing outstanding, or pop with
//                    credits already full
//   dbg_state        current FSM state encoding
//   dbg_credits      current credit counter
//   dbg_outstanding  response beats still expected from memory
module dma_read_scheduler #(
    parameter int ADDR_W        = 32,
    parameter int LEN_W         = 16,
    parameter int BITS_DEPTH    = 8,
    parameter int MAX_BURST     = 64,
    parameter int BOUNDARY_BITS = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    dma_read_scheduler_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state,
    output logic [BITS_DEPTH:0]   dbg_credits,
    output logic [LEN_W:0]        dbg_outstanding
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam int                   CAP         = 1 << BITS_DEPTH;
    localparam logic [BITS_DEPTH:0]  CAP_V       = (BITS_DEPTH+1)'(CAP);
    localparam logic [BITS_DEPTH:0]  CRED_ONE    = (BITS_DEPTH+1)'(1);
    localparam logic [BOUNDARY_BITS:0] BOUND_BYTES = (BOUNDARY_BITS+1)'(1 << BOUNDARY_BITS);
    localparam logic [31:0]          MAX_BURST_V = 32'(MAX_BURST);
    localparam logic [ADDR_W-1:0]    ADDR_MASK   = ~ADDR_W'(3);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [BITS_DEPTH:0]   blen_q, blen_d;
    logic [BITS_DEPTH:0]   credits_q, credits_d;
    logic [LEN_W:0]        outstanding_q, outstanding_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  issue;
    logic                  wr_en;
    logic                  pop_ok;
    logic [BOUNDARY_BITS:0] bound_words;
    logic [31:0]           burst_lim;

    // Words left before the next address boundary, then the burst length
    // as the smallest of remaining words, MAX_BURST and that distance.
    always_comb begin
        bound_words = (BOUND_BYTES - {1'b0, addr_q[BOUNDARY_BITS-1:0]}) >> 2;
        burst_lim   = 32'(remaining_q);
        if (burst_lim > MAX_BURST_V) begin
            burst_lim = MAX_BURST_V;
        end
        if (burst_lim > 32'(bound_words)) begin
            burst_lim = 32'(bound_words);
        end
    end

    // Counters run in every state. A pop arriving while credits are already
    // full would overflow the mirror of the FIFO, so it is dropped and flagged.
    always_comb begin
        issue  = (state_q == S_ISSUE) && bus.req_ready;
        wr_en  = bus.rsp_valid && (outstanding_q != '0);
        pop_ok = bus.fifo_pop && (credits_q != CAP_V);

        credits_d = credits_q;
        if (issue) begin
            credits_d = credits_d - blen_q;
        end
        if (pop_ok) begin
            credits_d = credits_d + CRED_ONE;
        end

        outstanding_d = outstanding_q;
        if (issue) begin
            outstanding_d = outstanding_d + (LEN_W+1)'(blen_q);
        end
        if (wr_en) begin
            outstanding_d = outstanding_d - (LEN_W+1)'(1);
        end

        error_d = error_q
                | (bus.fifo_pop && (credits_q == CAP_V))
                | (bus.rsp_valid && (outstanding_q == '0));
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        blen_d      = blen_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d      = bus.cmd_addr & ADDR_MASK;
                        remaining_d = bus.cmd_len;
                        state_d     = S_CALC;
                    end
                end
            end
            S_CALC: begin
                blen_d  = (BITS_DEPTH+1)'(burst_lim);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (credits_q >= blen_q) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.req_ready) begin
                    addr_d      = addr_q + ADDR_W'({blen_q, 2'b00});
                    remaining_d = remaining_q - LEN_W'(blen_q);
                    state_d     = (remaining_q != LEN_W'(blen_q)) ? S_CALC : S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Finish on the cycle the last expected beat lands.
                if (outstanding_d == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            blen_q        <= '0;
            credits_q     <= CAP_V;
            outstanding_q <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            blen_q        <= blen_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.req_valid   = (state_q == S_ISSUE);
    assign bus.req_addr    = addr_q;
    assign bus.req_len     = blen_q;
    assign bus.fifo_wr_en  = wr_en;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign error           = error_q;
    assign dbg_state       = state_q;
    assign dbg_credits     = credits_q;
    assign dbg_outstanding = outstanding_q;
endmodule
